// File: rtl/wb_if.sv
// Classic Wishbone signal bundle used on both sides of the peripheral bridge.
interface wb_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    we;
  logic                    cyc;
  logic                    stb;
  logic                    ack;
  logic                    err;

  modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
  modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/wb_periph_bridge.sv
// Registered single-outstanding Wishbone bridge with a downstream response timeout.
// Every output comes from a flop or from the state register alone.
module wb_periph_bridge #(
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rstn,
  wb_if.slave        s,
  wb_if.master       m,
  output logic       timeout_o,
  output logic [7:0] timeout_cnt_o
);

  localparam int unsigned SEL_WIDTH = WB_DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH =
    ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_accept;
  logic                     w_rsp_hit;
  logic                     w_timeout;

  logic [WB_ADDR_WIDTH-1:0] r_adr;
  logic [WB_DATA_WIDTH-1:0] r_dat_w;
  logic [SEL_WIDTH-1:0]     r_sel;
  logic                     r_we;
  logic [WB_DATA_WIDTH-1:0] r_rsp_data;
  logic                     r_s_ack;
  logic                     r_s_err;
  logic                     r_timeout;
  logic [7:0]               r_timeout_cnt;
  logic [CNT_WIDTH-1:0]     r_wait_cnt;

  // NOTE: state and datapath flops use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rsp_hit   = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (s.cyc && s.stb) begin
          w_accept    = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (m.ack || m.err) begin
          w_rsp_hit   = 1'b1;
          w_state_nxt = RSP;
        end else if (TIMEOUT_EN && (r_wait_cnt == CNT_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = RSP;
        end
      end
      RSP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The upstream response is decided on the REQ->RSP edge; an abandoned
  // upstream cycle (s.cyc low) swallows the response instead of signalling it.
  // NOTE: all datapath flops are reset so both buses show defined zeros
  // immediately on rstn, including mid-transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_adr         <= '0;
      r_dat_w       <= '0;
      r_sel         <= '0;
      r_we          <= 1'b0;
      r_rsp_data    <= '0;
      r_s_ack       <= 1'b0;
      r_s_err       <= 1'b0;
      r_timeout     <= 1'b0;
      r_timeout_cnt <= '0;
      r_wait_cnt    <= '0;
    end else begin
      r_s_ack   <= 1'b0;
      r_s_err   <= 1'b0;
      r_timeout <= 1'b0;

      if (w_accept) begin
        r_adr      <= s.adr;
        r_dat_w    <= s.dat_w;
        r_sel      <= s.sel;
        r_we       <= s.we;
        r_wait_cnt <= '0;
      end

      if (TIMEOUT_EN && (r_state == REQ) && !w_rsp_hit && !w_timeout)
        r_wait_cnt <= r_wait_cnt + 1'b1;

      if (w_rsp_hit) begin
        if (!r_we) r_rsp_data <= m.dat_r;
        r_s_ack <= s.cyc && !m.err;
        r_s_err <= s.cyc && m.err;
      end

      if (w_timeout) begin
        r_s_err   <= s.cyc;
        r_timeout <= 1'b1;
        if (r_timeout_cnt != 8'hFF) r_timeout_cnt <= r_timeout_cnt + 8'd1;
      end
    end
  end

  assign m.cyc   = (r_state == REQ);
  assign m.stb   = (r_state == REQ);
  assign m.adr   = r_adr;
  assign m.dat_w = r_dat_w;
  assign m.sel   = r_sel;
  assign m.we    = r_we;

  assign s.ack   = r_s_ack;
  assign s.err   = r_s_err;
  assign s.dat_r = r_rsp_data;

  assign timeout_o     = r_timeout;
  assign timeout_cnt_o = r_timeout_cnt;

endmodule
